// File: rtl/modinv_binary_if.sv
// Request/response bundle for the modular-inverse engine.
interface modinv_binary_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] n;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] o;

  modport master (output start, a, n, input busy, done, err, o);
  modport slave  (input start, a, n, output busy, done, err, o);
endinterface

// File: rtl/modinv_binary.sv
// Sequential modular inverse o = a^-1 mod n using binary extended Euclid,
// one reduction step per clock. Supplies r^-1 mod n for unblinding.
module modinv_binary #(
  parameter int unsigned N = 8
) (
  input  logic            clk,
  input  logic            rst,
  modinv_binary_if.slave  bus
);

  localparam int unsigned W1 = N + 1;

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  state_t       state, state_n;
  logic [N-1:0] u, u_n, v, v_n;
  logic [N-1:0] x1, x1_n, x2, x2_n;
  logic [N-1:0] nq, nq_n;
  logic [N-1:0] o_q, o_n;
  logic         err_q, err_n;
  logic         busy_q, busy_n;
  logic         done_q, done_n;

  // Halve x modulo odd m: odd x is made even by adding m in N+1 bits first.
  function automatic logic [N-1:0] half_mod(input logic [N-1:0] x, input logic [N-1:0] m);
    logic [W1-1:0] s;
    s = x[0] ? (W1'(x) + W1'(m)) : W1'(x);
    return N'(s >> 1);
  endfunction

  // (p - q) mod m for p, q in [0, m).
  function automatic logic [N-1:0] sub_mod(input logic [N-1:0] p, input logic [N-1:0] q,
                                           input logic [N-1:0] m);
    logic [W1-1:0] s;
    s = W1'(p) - W1'(q);
    if (p < q) s = s + W1'(m);
    return N'(s);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      u      <= '0;
      v      <= '0;
      x1     <= '0;
      x2     <= '0;
      nq     <= '0;
      o_q    <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      u      <= u_n;
      v      <= v_n;
      x1     <= x1_n;
      x2     <= x2_n;
      nq     <= nq_n;
      o_q    <= o_n;
      err_q  <= err_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    u_n     = u;
    v_n     = v;
    x1_n    = x1;
    x2_n    = x2;
    nq_n    = nq;
    o_n     = o_q;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          u_n     = bus.a;
          v_n     = bus.n;
          x1_n    = N'(1);
          x2_n    = '0;
          nq_n    = bus.n;
          o_n     = '0;
          err_n   = 1'b0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (!nq[0] || nq <= N'(1) || u == '0 || u >= nq) begin
          err_n   = 1'b1;
          o_n     = '0;
          state_n = DONE;
        end else if (u == N'(1)) begin
          o_n     = N'(1);
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      RUN: begin
        // Exit tests look at the registers before any step is applied.
        if (u == N'(1)) begin
          o_n     = x1;
          state_n = DONE;
        end else if (v == N'(1)) begin
          o_n     = x2;
          state_n = DONE;
        end else if (u == '0 || v == '0) begin
          err_n   = 1'b1;
          o_n     = '0;
          state_n = DONE;
        end else if (!u[0]) begin
          u_n  = u >> 1;
          x1_n = half_mod(x1, nq);
        end else if (!v[0]) begin
          v_n  = v >> 1;
          x2_n = half_mod(x2, nq);
        end else if (u >= v) begin
          u_n  = u - v;
          x1_n = sub_mod(x1, x2, nq);
        end else begin
          v_n  = v - u;
          x2_n = sub_mod(x2, x1, nq);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.o    = o_q;

endmodule

// File: tb/tb_modinv_binary.sv
// Scoreboard bench for modinv_binary: directed vectors plus a swept reference check.
module tb_modinv_binary;

  localparam int unsigned N      = 8;
  localparam int          BUDGET = 4 * N + 8;

  typedef struct packed {
    logic [N-1:0] o;
    logic         err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t mon_e;

  modinv_binary_if #(.N(N)) bus ();

  modinv_binary #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done o=%0d err=%0d required=no_done", bus.o, bus.err);
      end else begin
        mon_e = sb.pop_front();
        if (bus.o !== mon_e.o || bus.err !== mon_e.err) begin
          failures++;
          $display("FAIL result actual o=%0d err=%0d required o=%0d err=%0d",
                   bus.o, bus.err, mon_e.o, mon_e.err);
        end
      end
    end
  end

  // Issue one request; exact_lat > 0 demands done exactly that many cycles after start.
  // hold keeps start asserted with changing a through the done cycle.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tn,
                        input logic [N-1:0] eo, input logic ee,
                        input int exact_lat, input bit hold);
    int lat;
    bit busy_ok;
    bit seen;
    bus.start = 1'b1;
    bus.a     = ta;
    bus.n     = tn;
    sb.push_back('{o: eo, err: ee});
    busy_ok = 1'b1;
    seen    = 1'b0;
    lat     = 0;
    for (int i = 1; i <= BUDGET && !seen; i++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      else       bus.a = ta ^ 8'h5a ^ 8'(i);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout a=%0d n=%0d actual=no_done required=done_within_%0d", ta, tn, BUDGET);
      void'(sb.pop_back());
      bus.start = 1'b0;
    end else begin
      chk("busy_until_done", 32'(busy_ok), 32'd1);
      if (exact_lat > 0) chk("latency", 32'(lat), 32'(exact_lat));
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  function automatic exp_t ref_inv(input int ra, input int rn);
    exp_t r;
    int   g, x, y, t;
    r = '{o: '0, err: 1'b1};
    if (rn % 2 == 0 || rn <= 1 || ra == 0 || ra >= rn) return r;
    x = ra;
    y = rn;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    if (g != 1) return r;
    for (int c = 1; c < rn; c++)
      if ((ra * c) % rn == 1) begin
        r = '{o: N'(c), err: 1'b0};
        return r;
      end
    return r;
  endfunction

  initial begin
    exp_t e;
    int   ra;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.n     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_err",  32'(bus.err),  32'd0);
    chk("reset_o",    32'(bus.o),    32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(8'd3,   8'd7,   8'd5,   1'b0, 0, 1'b0);
    run_op(8'd200, 8'd251, 8'd187, 1'b0, 0, 1'b0);
    run_op(8'd1,   8'd9,   8'd1,   1'b0, 2, 1'b0);
    run_op(8'd6,   8'd9,   8'd0,   1'b1, 0, 1'b0);
    run_op(8'd5,   8'd8,   8'd0,   1'b1, 2, 1'b0);
    run_op(8'd0,   8'd7,   8'd0,   1'b1, 2, 1'b0);
    run_op(8'd9,   8'd7,   8'd0,   1'b1, 2, 1'b0);
    run_op(8'd0,   8'd1,   8'd0,   1'b1, 2, 1'b0);
    run_op(8'd2,   8'd7,   8'd4,   1'b0, 0, 1'b0);
    run_op(8'd5,   8'd11,  8'd9,   1'b0, 0, 1'b0);
    run_op(8'd10,  8'd13,  8'd4,   1'b0, 0, 1'b0);
    run_op(8'd7,   8'd9,   8'd4,   1'b0, 0, 1'b0);
    run_op(8'd254, 8'd255, 8'd254, 1'b0, 0, 1'b0);
    run_op(8'd2,   8'd255, 8'd128, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("o_held", 32'(bus.o), 32'd128);

    // start held high with changing a: only the first operands count
    run_op(8'd3, 8'd7, 8'd5, 1'b0, 0, 1'b1);
    repeat (4) @(negedge clk);
    chk("no_restart_busy", 32'(bus.busy), 32'd0);

    // reset pulse in the middle of a long run
    bus.start = 1'b1;
    bus.a     = 8'd200;
    bus.n     = 8'd251;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_o",    32'(bus.o),    32'd0);
    chk("abort_err",  32'(bus.err),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    run_op(8'd3, 8'd7, 8'd5, 1'b0, 0, 1'b0);

    // sweep every odd modulus with a random operand against a brute-force reference
    for (int rn = 1; rn < 256; rn += 2) begin
      ra = $urandom_range(rn - 1, 0);
      e  = ref_inv(ra, rn);
      run_op(N'(ra), N'(rn), e.o, e.err, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
